// File: rtl/hir_stencil_pkg.sv
// Shared constants for the streaming binomial stencil: per-K row coefficients,
// normalisation shifts, accumulator sizing and pipeline latency.
package hir_stencil_pkg;

  localparam int LATENCY = 3;

  localparam int ROW_COEF_K3 [3] = '{1, 2, 1};
  localparam int ROW_COEF_K5 [5] = '{1, 4, 6, 4, 1};

  localparam int NORM_K3 = 4;
  localparam int NORM_K5 = 8;

  function automatic int norm_of(input int k);
    return (k == 5) ? NORM_K5 : NORM_K3;
  endfunction

  // Sum of all 2-D coefficients is 2^NORM, so NORM extra bits never overflow.
  function automatic int acc_width(input int width, input int k);
    return width + norm_of(k);
  endfunction

  function automatic int row_coef(input int k, input int idx);
    int c;
    c = 0;
    if (k == 5) begin
      for (int i = 0; i < 5; i++) begin
        if (i == idx) c = ROW_COEF_K5[i];
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (i == idx) c = ROW_COEF_K3[i];
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/stencil_line_buffer.sv
// Holds TAPS previous rows; every accepted pixel shifts all rows by one
// position, so tap t is the pixel from (t+1)*LINE_W accepted pixels ago.
module stencil_line_buffer #(
  parameter int WIDTH  = 32,
  parameter int LINE_W = 64,
  parameter int TAPS   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       shift_en,
  input  logic [WIDTH-1:0]           in_data,
  output logic [TAPS-1:0][WIDTH-1:0] taps
);

  localparam int PTR_W = $clog2(LINE_W);

  logic [PTR_W-1:0] ptr;
  logic [WIDTH-1:0] mem [TAPS][LINE_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (shift_en) begin
      ptr <= (ptr == PTR_W'(LINE_W - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

  // RAM is never cleared; the caller masks stale rows with its counters.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[0][ptr] <= in_data;
      for (int t = 1; t < TAPS; t++) begin
        mem[t][ptr] <= mem[t-1][ptr];
      end
    end
  end

  always_comb begin
    for (int t = 0; t < TAPS; t++) begin
      taps[t] = mem[t][ptr];
    end
  end

endmodule

// File: rtl/stencil_avg.sv
// Streaming KxK binomial weighted average: raster-order pixels in, one
// normalised result per complete window out, fixed 3-cycle latency.
module stencil_avg
  import hir_stencil_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int K      = 3,
  parameter int LINE_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tstart,
  input  logic             frame_start,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  localparam int NORM  = norm_of(K);
  localparam int ACC_W = acc_width(WIDTH, K);
  localparam int COL_W = $clog2(LINE_W);
  localparam int ROW_W = $clog2(K);

  logic [COL_W-1:0]           col;
  logic [COL_W-1:0]           pos_col;
  logic [COL_W-1:0]           col_next;
  logic [ROW_W-1:0]           row;
  logic [ROW_W-1:0]           pos_row;
  logic [ROW_W-1:0]           row_next;
  logic                       window_ok;
  logic [LATENCY-1:0]         vpipe;
  logic [K-2:0][WIDTH-1:0]    taps;
  logic [WIDTH-1:0]           col_in  [K];
  logic [WIDTH-1:0]           win     [K][K];
  logic [ACC_W-1:0]           prod    [K][K];
  logic [ACC_W-1:0]           row_sum_c [K];
  logic [ACC_W-1:0]           row_sum   [K];
  logic [ACC_W-1:0]           total_c;
  logic [WIDTH-1:0]           avg_c;

  // frame_start relocates the current pixel to (0,0) before validity is judged.
  always_comb begin
    pos_col   = frame_start ? '0 : col;
    pos_row   = frame_start ? '0 : row;
    window_ok = tstart && (pos_row == ROW_W'(K - 1)) && (pos_col >= COL_W'(K - 1));
    col_next  = col;
    row_next  = row;
    if (tstart) begin
      if (pos_col == COL_W'(LINE_W - 1)) begin
        col_next = '0;
        row_next = (pos_row == ROW_W'(K - 1)) ? pos_row : pos_row + ROW_W'(1);
      end else begin
        col_next = pos_col + COL_W'(1);
        row_next = pos_row;
      end
    end else if (frame_start) begin
      col_next = '0;
      row_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_next;
      row <= row_next;
    end
  end

  stencil_line_buffer #(
    .WIDTH  (WIDTH),
    .LINE_W (LINE_W),
    .TAPS   (K - 1)
  ) u_line_buffer (
    .clk      (clk),
    .rst      (rst),
    .shift_en (tstart),
    .in_data  (in_data),
    .taps     (taps)
  );

  // Window row K-1 is the current row; row 0 is the oldest buffered row.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      col_in[r] = taps[K-2-r];
    end
    col_in[K-1] = in_data;
  end

  always_ff @(posedge clk) begin
    if (tstart) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][K-1] <= col_in[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vpipe[0]) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          prod[i][j] <= ACC_W'(win[i][j]) * ACC_W'(row_coef(K, i) * row_coef(K, j));
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < K; i++) begin
      row_sum_c[i] = '0;
      for (int j = 0; j < K; j++) begin
        row_sum_c[i] = row_sum_c[i] + prod[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vpipe[1]) begin
      row_sum <= row_sum_c;
    end
  end

  always_comb begin
    total_c = '0;
    for (int i = 0; i < K; i++) begin
      total_c = total_c + row_sum[i];
    end
    avg_c = WIDTH'(total_c >> NORM);
  end

  // Only the valid pipeline and output are reset, so rst discards in-flight work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      vpipe     <= {vpipe[LATENCY-2:0], window_ok};
      out_valid <= vpipe[LATENCY-1];
      if (vpipe[LATENCY-1]) begin
        out <= avg_c;
      end
    end
  end

endmodule

// File: tb/tb_stencil_avg.sv
// Self-checking bench for stencil_avg: K=3 and K=5 instances share one pixel
// stream and are compared every cycle against a frame-level reference model.
module tb_stencil_avg;

  localparam int LW   = 8;
  localparam int MAXC = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tstart = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] out3, out5;
  logic        out_valid3, out_valid5;

  stencil_avg #(.WIDTH(32), .K(3), .LINE_W(LW)) dut3 (
    .clk(clk), .rst(rst), .tstart(tstart), .frame_start(frame_start),
    .in_data(in_data), .out(out3), .out_valid(out_valid3)
  );

  stencil_avg #(.WIDTH(32), .K(5), .LINE_W(LW)) dut5 (
    .clk(clk), .rst(rst), .tstart(tstart), .frame_start(frame_start),
    .in_data(in_data), .out(out5), .out_valid(out_valid5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  bit          exp_v3 [MAXC];
  bit          exp_v5 [MAXC];
  logic [31:0] exp_d3 [MAXC];
  logic [31:0] exp_d5 [MAXC];
  logic [31:0] model_out3 = '0;
  logic [31:0] model_out5 = '0;
  logic [31:0] frame_q [$];
  logic [31:0] seq3 [$];
  logic [31:0] seq5 [$];
  logic [31:0] imp3 [$];
  logic [31:0] imp5 [$];
  int          first_valid3 = -1;
  int          last_acc_cyc = 0;
  bit          monitor_on = 1'b0;

  function automatic longint binom(input int n, input int k);
    longint b = 1;
    for (int i = 0; i < k; i++) b = b * (n - i) / (i + 1);
    return b;
  endfunction

  // Reference: binomial-weighted sum over the frame image, shifted by log2 of total weight.
  function automatic logic [31:0] window_val(input int k, input int n);
    int     r = n / LW;
    int     c = n % LW;
    longint sum = 0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        sum += binom(k - 1, i) * binom(k - 1, j) *
               longint'(frame_q[(r - k + 1 + i) * LW + (c - k + 1 + j)]);
    return 32'(sum >> (2 * (k - 1)));
  endfunction

  function automatic logic [31:0] pix_of(input int kind, input int i);
    case (kind)
      0:       return 32'd16;
      1:       return (i == 3 * LW + 3) ? 32'd256 : 32'd0;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Drives one cycle and books the expected result for the edge 3 cycles after acceptance.
  task automatic applyStimulus(input bit ts, input bit fs, input logic [31:0] pix);
    int n;
    int idx;
    @(negedge clk);
    tstart      = ts;
    frame_start = fs;
    in_data     = pix;
    if (fs) frame_q.delete();
    if (ts) begin
      frame_q.push_back(pix);
      n            = frame_q.size() - 1;
      last_acc_cyc = cyc + 1;
      idx          = cyc + 4;
      if (idx < MAXC) begin
        if (n / LW >= 2 && n % LW >= 2) begin
          exp_v3[idx] = 1'b1;
          exp_d3[idx] = window_val(3, n);
        end
        if (n / LW >= 4 && n % LW >= 4) begin
          exp_v5[idx] = 1'b1;
          exp_d5[idx] = window_val(5, n);
        end
      end
    end
  endtask

  task automatic feedFrame(input int kind, input int duty, input int npix, input bit fs_first);
    for (int i = 0; i < npix; i++) begin
      while (duty < 100 && $urandom_range(99) >= duty) applyStimulus(1'b0, 1'b0, $urandom);
      applyStimulus(1'b1, (i == 0) && fs_first, pix_of(kind, i));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, '0);
  endtask

  task automatic clearSeq();
    seq3.delete();
    seq5.delete();
    first_valid3 = -1;
  endtask

  task automatic doReset();
    #2;
    rst         = 1'b1;
    tstart      = 1'b0;
    frame_start = 1'b0;
    for (int i = 0; i < MAXC; i++) begin
      exp_v3[i] = 1'b0;
      exp_v5[i] = 1'b0;
    end
    model_out3 = '0;
    model_out5 = '0;
    frame_q.delete();
    #1;
    checkOutput("rst_valid_k3", out_valid3, 0);
    checkOutput("rst_valid_k5", out_valid5, 0);
    checkOutput("rst_out_k3", out3, 0);
    checkOutput("rst_out_k5", out5, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Every cycle: out_valid must match the booked schedule, out must hold the last result.
  always @(negedge clk) begin
    if (monitor_on) begin
      if (cyc < MAXC) begin
        if (exp_v3[cyc]) model_out3 = exp_d3[cyc];
        if (exp_v5[cyc]) model_out5 = exp_d5[cyc];
        checkOutput("valid_k3", out_valid3, exp_v3[cyc]);
        checkOutput("out_k3", out3, model_out3);
        checkOutput("valid_k5", out_valid5, exp_v5[cyc]);
        checkOutput("out_k5", out5, model_out5);
      end
      if (out_valid3) begin
        seq3.push_back(out3);
        if (first_valid3 < 0) first_valid3 = cyc;
      end
      if (out_valid5) seq5.push_back(out5);
    end
  end

  initial begin
    #60000;
    $display("[TB] FAIL watchdog cycle=%0d expected=finish", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] imp_ref [9];
    logic [31:0] nz [$];
    int          bad;
    int          acc18;
    logic [31:0] mx;

    imp_ref = '{32'd16, 32'd32, 32'd16, 32'd32, 32'd64, 32'd32, 32'd16, 32'd32, 32'd16};

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    monitor_on = 1'b1;
    checkOutput("reset_out_k3", out3, 0);
    checkOutput("reset_valid_k3", out_valid3, 0);
    checkOutput("reset_out_k5", out5, 0);
    checkOutput("reset_valid_k5", out_valid5, 0);
    rst = 1'b0;

    // Constant frame of 16.
    clearSeq();
    feedFrame(0, 100, 64, 1'b1);
    idle(6);
    checkOutput("const_count_k3", seq3.size(), 36);
    checkOutput("const_count_k5", seq5.size(), 16);
    bad = 0;
    foreach (seq3[i]) if (seq3[i] !== 32'd16) bad++;
    foreach (seq5[i]) if (seq5[i] !== 32'd16) bad++;
    checkOutput("const_values", bad, 0);

    // Impulse of 256 at (3,3), streamed back to back.
    clearSeq();
    feedFrame(1, 100, 64, 1'b1);
    idle(6);
    imp3 = seq3;
    imp5 = seq5;
    nz.delete();
    foreach (seq3[i]) if (seq3[i] != 0) nz.push_back(seq3[i]);
    checkOutput("impulse_nz_count_k3", nz.size(), 9);
    for (int i = 0; i < 9; i++) checkOutput("impulse_k3", (i < nz.size()) ? nz[i] : 32'hDEAD, imp_ref[i]);
    mx = '0;
    foreach (seq5[i]) if (seq5[i] > mx) mx = seq5[i];
    checkOutput("impulse_centre_k5", mx, 36);
    checkOutput("impulse_count_k5", seq5.size(), 16);

    // Same impulse with tstart at 40% duty must give the same result sequence.
    clearSeq();
    feedFrame(1, 40, 64, 1'b1);
    idle(6);
    checkOutput("gapped_count_k3", seq3.size(), imp3.size());
    checkOutput("gapped_count_k5", seq5.size(), imp5.size());
    bad = 0;
    foreach (imp3[i]) if (i >= seq3.size() || seq3[i] !== imp3[i]) bad++;
    foreach (imp5[i]) if (i >= seq5.size() || seq5[i] !== imp5[i]) bad++;
    checkOutput("gapped_sequence", bad, 0);

    // Full-scale pixels must not wrap.
    clearSeq();
    feedFrame(2, 100, 64, 1'b1);
    idle(6);
    checkOutput("full_count_k3", seq3.size(), 36);
    bad = 0;
    foreach (seq3[i]) if (seq3[i] !== 32'hFFFF_FFFF) bad++;
    foreach (seq5[i]) if (seq5[i] !== 32'hFFFF_FFFF) bad++;
    checkOutput("full_values", bad, 0);

    // Random pixels, gapped, with a frame_start that consumes no pixel mid-frame.
    feedFrame(3, 60, 20, 1'b1);
    applyStimulus(1'b0, 1'b1, $urandom);
    feedFrame(3, 60, 64, 1'b0);
    idle(6);

    // Reset in row 4 while results are in flight.
    feedFrame(3, 100, 38, 1'b1);
    @(negedge clk);
    checkOutput("pre_rst_valid_k3", out_valid3, 1);
    doReset();

    // New frame interrupted by frame_start+tstart at row 1, col 5.
    feedFrame(3, 100, 13, 1'b1);
    clearSeq();
    acc18 = 0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, i == 0, $urandom);
      if (i == 18) acc18 = last_acc_cyc;
    end
    idle(6);
    checkOutput("restart_first_valid", first_valid3, acc18 + 3);
    checkOutput("restart_count_k3", seq3.size(), 36);
    checkOutput("restart_count_k5", seq5.size(), 16);

    monitor_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
